// File: rtl/pipelined_alu.sv
// pipelined_alu: valid/ready ALU with single-cycle logic/arith ops and an
// iterative shift-add multiplier. One operation in flight at a time; the
// result and NZCV flags are held in registers until the consumer takes them.
module pipelined_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   result_r;
    logic               flag_n_r;
    logic               flag_z_r;
    logic               flag_c_r;
    logic               flag_v_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [SHW-1:0]     cnt_r;

    // Single-cycle datapath; the extra top/bottom bit of each vector holds
    // carry, borrow or the last bit shifted out.
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     shr_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_c_s;
    logic               alu_v_s;
    logic [2*WIDTH-1:0] mul_addend_s;
    logic [2*WIDTH-1:0] prod_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};
    assign shl_s  = {1'b0, a} << b[SHW-1:0];
    assign shr_s  = {a, 1'b0} >> b[SHW-1:0];

    assign mul_addend_s = mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}};
    assign prod_s       = acc_r + mul_addend_s;

    // Select the single-cycle result and carry/overflow for the incoming op.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[WIDTH-1:0];
                alu_c_s   = diff_s[WIDTH];
                alu_v_s   = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff_s[WIDTH-1]);
            end
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_SHL: begin
                alu_res_s = shl_s[WIDTH-1:0];
                alu_c_s   = shl_s[WIDTH];
            end
            OP_SHR: begin
                alu_res_s = shr_s[WIDTH:1];
                alu_c_s   = shr_s[0];
            end
            OP_XOR: alu_res_s = a ^ b;
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_c_s   = 1'b0;
                alu_v_s   = 1'b0;
            end
        endcase
    end

    // Control FSM plus result/flag registers and the shift-add multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            result_r <= {WIDTH{1'b0}};
            flag_n_r <= 1'b0;
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
            flag_v_r <= 1'b0;
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {SHW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            state_r  <= ST_MUL;
                            mcand_r  <= {{WIDTH{1'b0}}, a};
                            mplier_r <= b;
                            acc_r    <= {(2*WIDTH){1'b0}};
                            cnt_r    <= {SHW{1'b0}};
                        end else begin
                            state_r  <= ST_DONE;
                            result_r <= alu_res_s;
                            flag_n_r <= alu_res_s[WIDTH-1];
                            flag_z_r <= (alu_res_s == {WIDTH{1'b0}});
                            flag_c_r <= alu_c_s;
                            flag_v_r <= alu_v_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_r    <= prod_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + SHW'(1);
                    if (cnt_r == LAST_ITER) begin
                        state_r  <= ST_DONE;
                        result_r <= prod_s[WIDTH-1:0];
                        flag_n_r <= prod_s[WIDTH-1];
                        flag_z_r <= (prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        flag_c_r <= |prod_s[2*WIDTH-1:WIDTH];
                        flag_v_r <= 1'b0;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_MUL);
    assign result    = result_r;
    assign flag_n    = flag_n_r;
    assign flag_z    = flag_z_r;
    assign flag_c    = flag_c_r;
    assign flag_v    = flag_v_r;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu (WIDTH=8): directed corner cases followed by
// randomized operations, all compared against an arithmetic reference model.
module tb_pipelined_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;
    logic         busy;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [W-1:0] obs_res;
    logic [3:0]   obs_flags;

    pipelined_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] r, output logic [3:0] nzcv);
        int xi, yi, full, amt;
        logic n, z, c, v;
        xi = int'(x);
        yi = int'(y);
        amt = yi % 8;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0: begin full = xi + yi; c = (full > 255); end
            3'd1: begin full = xi - yi + 256; c = (xi < yi); end
            3'd2: full = int'(x & y);
            3'd3: full = int'(x | y);
            3'd4: begin full = xi * yi; c = (full > 255); end
            3'd5: begin full = xi << amt; c = (amt != 0) && (((xi >> (8 - amt)) & 1) == 1); end
            3'd6: begin full = xi >> amt; c = (amt != 0) && (((xi >> (amt - 1)) & 1) == 1); end
            3'd7: full = int'(x ^ y);
            default: full = 0;
        endcase
        r = 8'(full % 256);
        if (o == 3'd0) v = (x[7] == y[7]) && (r[7] != x[7]);
        if (o == 3'd1) v = (x[7] != y[7]) && (r[7] != x[7]);
        n = r[7];
        z = (r == 8'd0);
        nzcv = {n, z, c, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the result and compare with the model.
    task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input bit release_it);
        logic [7:0] er;
        logic [3:0] ef;
        int cyc, bcnt;
        model(o, x, y, er, ef);
        check({name, "_pre_ready"}, 32'(in_ready), 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
        cyc = 1; bcnt = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), (o == 3'd4) ? 32'd9 : 32'd1);
        check({name, "_busy_cycles"}, 32'(bcnt), (o == 3'd4) ? 32'd8 : 32'd0);
        check({name, "_res"}, 32'(result), 32'(er));
        check({name, "_nzcv"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(ef));
        obs_res = result;
        obs_flags = {flag_n, flag_z, flag_c, flag_v};
        if (release_it) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({name, "_back_idle"}, 32'({in_ready, out_valid}), 32'b10);
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [7:0] held_res;
        logic [3:0] held_flags;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'd0; b = 8'd0; op = 3'd0;
        #3;
        check("reset_state", 32'({in_ready, out_valid, busy}), 32'b100);
        check("reset_out", 32'({result, flag_n, flag_z, flag_c, flag_v}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD overflow into the sign bit.
        run_op("add7f", 3'd0, 8'h7F, 8'h01, 1'b1);
        check("add7f_res_k", 32'(obs_res), 32'h80);
        check("add7f_nzcv_k", 32'(obs_flags), 32'b1001);

        // SUB borrow.
        run_op("sub0", 3'd1, 8'h00, 8'h01, 1'b1);
        check("sub0_res_k", 32'(obs_res), 32'hFF);
        check("sub0_nzcv_k", 32'(obs_flags), 32'b1010);

        // MUL with product spilling entirely into the high half.
        run_op("mul10", 3'd4, 8'h10, 8'h10, 1'b1);
        check("mul10_res_k", 32'(obs_res), 32'h00);
        check("mul10_zc_k", 32'(obs_flags[2:1]), 32'b11);

        // SHL by 1 and by 8 (amount wraps to 0).
        run_op("shl1", 3'd5, 8'h81, 8'h01, 1'b1);
        check("shl1_res_k", 32'(obs_res), 32'h02);
        check("shl1_c_k", 32'(obs_flags[1]), 32'd1);
        run_op("shl8", 3'd5, 8'h81, 8'h08, 1'b1);
        check("shl8_res_k", 32'(obs_res), 32'h81);
        check("shl8_nc_k", 32'({obs_flags[3], obs_flags[1]}), 32'b10);

        // Back-pressure: hold the AND result while an ADD request is offered.
        run_op("and_hold", 3'd2, 8'hF0, 8'h3C, 1'b0);
        held_res = result;
        held_flags = {flag_n, flag_z, flag_c, flag_v};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 3'd0; a = 8'h11; b = 8'h22;
            @(posedge clk); #1;
            check("hold_res", 32'(result), 32'(held_res));
            check("hold_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'(held_flags));
            check("hold_hs", 32'({in_ready, out_valid}), 32'b01);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("hold_not_queued", 32'({in_ready, out_valid, busy}), 32'b100);
        check("hold_res_kept", 32'(result), 32'h30);

        // Reset asserted in the third MUL cycle.
        op = 3'd4; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mulrst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mulrst_state", 32'({in_ready, out_valid, busy}), 32'b100);
        check("mulrst_out", 32'({result, flag_n, flag_z, flag_c, flag_v}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("mulrst_no_output", 32'(seen), 32'd0);
        run_op("add_after_rst", 3'd0, 8'h02, 8'h03, 1'b1);
        check("add_after_rst_k", 32'(obs_res), 32'h05);

        // Randomized operations against the model.
        for (int i = 0; i < 30; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
